switch_debouncer: RTL and testbench

Debounces and synchronizes N raw board slide switches before they reach the switch-to-LED mapping stage. Each bit passes through a two-flop synchronizer and then a per-bit stability counter. A new level is forwarded on `o_switch` only after it has been held for `DEBOUNCE_CYCLES` consecutive clocks. `o_switch` drives the downstream block's `i_switch` bus directly; `o_changed` flags each accepted transition for optional event logic.

---
 rtl/switch_debouncer.sv | 75 +++++++
 tb/tb_switch_debouncer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : switch_debouncer
// Purpose  : Synchronises N raw slide-switch pins into the clock domain and
//            forwards a new level only after it has been stable for
//            DEBOUNCE_CYCLES consecutive clocks. A one-cycle pulse on
//            o_changed marks each accepted transition.
// Revision : 1.0 - initial release
// ============================================================================
module switch_debouncer #(
  parameter int N               = 4,
  // Must be at least 2; smaller values leave no room for a count.
  parameter int DEBOUNCE_CYCLES = 250000,
  // Derived from DEBOUNCE_CYCLES; not meant to be overridden.
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [N-1:0] i_switch_raw,
  output logic [N-1:0] o_switch,
  output logic [N-1:0] o_changed
);

  // Last count value before a mismatching level is accepted.
  localparam logic [CNT_W-1:0] C_TERMINAL = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Two-stage synchroniser; only s2 is allowed to feed any logic.
  logic [N-1:0]     s1;
  logic [N-1:0]     s2;

  // Per-channel stability counters, each independent of the others.
  logic [CNT_W-1:0] cnt [N];

  // Synchroniser flops: bring the asynchronous pins into the clk domain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= i_switch_raw;
      s2 <= s1;
    end
  end

  // Per-bit debounce: count consecutive mismatching clocks, accept at terminal
  // count, and drop all progress on any single-cycle return to the held level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < N; i++) begin
        cnt[i] <= '0;
      end
      o_switch  <= '0;
      o_changed <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (s2[i] == o_switch[i]) begin
          // Stable (or a glitch just ended): no partial credit is kept.
          cnt[i]       <= '0;
          o_changed[i] <= 1'b0;
        end else if (cnt[i] == C_TERMINAL) begin
          // Held long enough: accept the new level and pulse once.
          o_switch[i]  <= s2[i];
          cnt[i]       <= '0;
          o_changed[i] <= 1'b1;
        end else begin
          // Still counting; the terminal check above keeps this from wrapping.
          cnt[i]       <= cnt[i] + CNT_W'(1);
          o_changed[i] <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_switch_debouncer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_switch_debouncer
// Purpose  : Directed self-checking bench for switch_debouncer with N=4 and
//            DEBOUNCE_CYCLES=4 on a 1 us clock. Expected values are written
//            by hand from the stated latency of 6 edges after a raw change.
// Revision : 1.0 - initial release
// ============================================================================
module tb_switch_debouncer;

  localparam int N  = 4;
  localparam int DC = 4;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] switch_raw;
  logic [N-1:0] sw_out;
  logic [N-1:0] changed;

  int checks;
  int errors;

  switch_debouncer #(
    .N               (N),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_switch_raw (switch_raw),
    .o_switch     (sw_out),
    .o_changed    (changed)
  );

  // 1 us period clock.
  initial clk = 1'b0;
  always #500 clk = ~clk;

  // Advance to just after the next rising edge, where outputs are sampled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    switch_raw = 4'b1111;
    repeat (3) tick();
    checks++;
    if (sw_out !== 4'b0000 || changed !== 4'b0000) begin
      errors++;
      $display("FAIL reset_hold: o_switch=%b o_changed=%b expected 0000 0000", sw_out, changed);
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 5) begin
        checks++;
        if (sw_out !== 4'b0000 || changed !== 4'b0000) begin
          errors++;
          $display("FAIL reset_edge5: o_switch=%b o_changed=%b expected 0000 0000", sw_out, changed);
        end
      end else if (e == 6) begin
        checks++;
        if (sw_out !== 4'b1111 || changed !== 4'b1111) begin
          errors++;
          $display("FAIL reset_edge6: o_switch=%b o_changed=%b expected 1111 1111", sw_out, changed);
        end
      end else if (e == 7) begin
        checks++;
        if (sw_out !== 4'b1111 || changed !== 4'b0000) begin
          errors++;
          $display("FAIL reset_edge7: o_switch=%b o_changed=%b expected 1111 0000", sw_out, changed);
        end
      end
    end
  endtask

  task automatic test_clean_step();
    switch_raw = 4'b0000;
    repeat (10) tick();
    checks++;
    if (sw_out !== 4'b0000) begin
      errors++;
      $display("FAIL step_settle_low: o_switch=%b expected 0000", sw_out);
    end
    switch_raw = 4'b0100;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 5) begin
        checks++;
        if (sw_out !== 4'b0000 || changed !== 4'b0000) begin
          errors++;
          $display("FAIL step_edge5: o_switch=%b o_changed=%b expected 0000 0000", sw_out, changed);
        end
      end else if (e == 6) begin
        checks++;
        if (sw_out !== 4'b0100 || changed !== 4'b0100) begin
          errors++;
          $display("FAIL step_edge6: o_switch=%b o_changed=%b expected 0100 0100", sw_out, changed);
        end
      end else if (e == 7) begin
        checks++;
        if (sw_out !== 4'b0100 || changed !== 4'b0000) begin
          errors++;
          $display("FAIL step_edge7: o_switch=%b o_changed=%b expected 0100 0000", sw_out, changed);
        end
      end
    end
    // Return to all-low for the next scenario.
    switch_raw = 4'b0000;
    repeat (10) tick();
  endtask

  task automatic test_glitch();
    logic bad;
    bad = 1'b0;
    switch_raw = 4'b0010;
    repeat (3) begin
      tick();
      if (sw_out !== 4'b0000 || changed !== 4'b0000) bad = 1'b1;
    end
    switch_raw = 4'b0000;
    repeat (10) begin
      tick();
      if (sw_out !== 4'b0000 || changed !== 4'b0000) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0 || sw_out !== 4'b0000) begin
      errors++;
      $display("FAIL glitch_reject: o_switch=%b o_changed=%b expected 0000 0000 throughout", sw_out, changed);
    end
  endtask

  task automatic test_bounce();
    // One raw value of bit 3 per clock: 2 high, 1 low, 2 high, 1 low.
    logic [5:0] pattern;
    logic       early;
    pattern = 6'b011011;
    early   = 1'b0;
    for (int k = 0; k < 6; k++) begin
      switch_raw = {pattern[k], 3'b000};
      tick();
      if (sw_out[3] !== 1'b0 || changed[3] !== 1'b0) early = 1'b1;
    end
    checks++;
    if (early !== 1'b0) begin
      errors++;
      $display("FAIL bounce_phase: o_switch[3] rose during bounce, o_switch=%b expected 0000", sw_out);
    end
    switch_raw = 4'b1000;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e <= 5 && (sw_out[3] !== 1'b0 || changed[3] !== 1'b0)) early = 1'b1;
    end
    checks++;
    if (early !== 1'b0) begin
      errors++;
      $display("FAIL bounce_early: o_switch[3] rose before edge 6 after settle, expected 0");
    end
    checks++;
    if (sw_out !== 4'b1000 || changed !== 4'b1000) begin
      errors++;
      $display("FAIL bounce_edge6: o_switch=%b o_changed=%b expected 1000 1000", sw_out, changed);
    end
    switch_raw = 4'b0000;
    repeat (10) tick();
    checks++;
    if (sw_out !== 4'b0000) begin
      errors++;
      $display("FAIL bounce_release: o_switch=%b expected 0000", sw_out);
    end
  endtask

  task automatic test_back_to_back();
    switch_raw = 4'b1010;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (e == 6) begin
        checks++;
        if (sw_out !== 4'b1010 || changed !== 4'b1010) begin
          errors++;
          $display("FAIL b2b_first: o_switch=%b o_changed=%b expected 1010 1010", sw_out, changed);
        end
      end
    end
    switch_raw = 4'b0101;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (e == 5) begin
        checks++;
        if (sw_out !== 4'b1010 || changed !== 4'b0000) begin
          errors++;
          $display("FAIL b2b_hold: o_switch=%b o_changed=%b expected 1010 0000", sw_out, changed);
        end
      end else if (e == 6) begin
        checks++;
        if (sw_out !== 4'b0101 || changed !== 4'b1111) begin
          errors++;
          $display("FAIL b2b_second: o_switch=%b o_changed=%b expected 0101 1111", sw_out, changed);
        end
      end else if (e == 7) begin
        checks++;
        if (sw_out !== 4'b0101 || changed !== 4'b0000) begin
          errors++;
          $display("FAIL b2b_after: o_switch=%b o_changed=%b expected 0101 0000", sw_out, changed);
        end
      end
    end
  endtask

  task automatic test_midcount_reset();
    // Establish a non-zero output so the asynchronous clear is observable.
    switch_raw = 4'b1010;
    repeat (10) tick();
    switch_raw = 4'b1011;
    // Edges 1-2 fill the synchroniser, edges 3-4 are two counting edges.
    repeat (4) tick();
    checks++;
    if (sw_out !== 4'b1010) begin
      errors++;
      $display("FAIL midcount_pre: o_switch=%b expected 1010", sw_out);
    end
    #200;
    rst_n = 1'b0;
    #1;
    checks++;
    if (sw_out !== 4'b0000 || changed !== 4'b0000) begin
      errors++;
      $display("FAIL midcount_async: o_switch=%b o_changed=%b expected 0000 0000 before next edge", sw_out, changed);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 5) begin
        checks++;
        if (sw_out !== 4'b0000 || changed !== 4'b0000) begin
          errors++;
          $display("FAIL midcount_edge5: o_switch=%b o_changed=%b expected 0000 0000", sw_out, changed);
        end
      end else if (e == 6) begin
        checks++;
        if (sw_out !== 4'b1011 || changed !== 4'b1011) begin
          errors++;
          $display("FAIL midcount_edge6: o_switch=%b o_changed=%b expected 1011 1011", sw_out, changed);
        end
      end else if (e == 7) begin
        checks++;
        if (sw_out !== 4'b1011 || changed !== 4'b0000) begin
          errors++;
          $display("FAIL midcount_edge7: o_switch=%b o_changed=%b expected 1011 0000", sw_out, changed);
        end
      end
    end
  endtask

  // Scenario sequence and summary.
  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    switch_raw = '0;
    test_reset();
    test_clean_step();
    test_glitch();
    test_bounce();
    test_back_to_back();
    test_midcount_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety bound on total run time.
  initial begin
    #2000000;
    $display("FAIL watchdog: run exceeded 2000 clocks, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
